// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO that drains one byte per frame into a busy-handshaked UART transmitter
// Optional entry-count output port: define UART_TX_FIFO_LEVEL_EN.
module uart_tx_fifo #(
    parameter int ADDR_BITS = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wrEnable,
    input  logic [DATA_BITS-1:0] wrData,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow,
    input  logic                 clearOverflow,
    output logic                 txEnable,
    output logic [DATA_BITS-1:0] txData,
    input  logic                 txBusy
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    output logic [ADDR_BITS:0]   level
`endif
);

    localparam int                   DEPTH      = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0]   COUNT_FULL = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0]   COUNT_ONE  = 1;
    localparam logic [ADDR_BITS-1:0] PTR_ONE    = 1;
    // The ISSUE cycle is the first quiet cycle, so one quiet WAIT_BUSY cycle
    // completes the two-cycle grace window for late or instant transmitters.
    localparam logic [1:0]           QUIET_WB_CYCLES = 2'd1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]   count_q, count_d;
    state_t               state_q, state_d;
    logic [1:0]           wait_cnt_q, wait_cnt_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic                 overflow_q, overflow_d;
    logic                 push, drop, pop;

    assign full     = (count_q == COUNT_FULL);
    assign empty    = (count_q == '0);
    assign overflow = overflow_q;
    assign txEnable = (state_q == ISSUE);
    assign txData   = tx_data_q;
`ifdef UART_TX_FIFO_LEVEL_EN
    assign level    = count_q;
`endif

    assign push = wrEnable && !full;
    assign drop = wrEnable && full;
    assign pop  = (state_q == IDLE) && !empty && !txBusy;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clearOverflow) begin
            overflow_d = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        tx_data_d  = tx_data_q;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    tx_data_d = mem_q[rd_ptr_q];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                wait_cnt_d = '0;
                state_d    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (txBusy) begin
                    state_d = WAIT_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                    if (wait_cnt_q + 2'd1 == QUIET_WB_CYCLES) begin
                        state_d = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!txBusy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; entries are only readable after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wrData;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed scoreboard bench for uart_tx_fifo with a behavioural UART busy model
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       wrEnable;
    logic [7:0] wrData;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       clearOverflow;
    logic       txEnable;
    logic [7:0] txData;
    logic       txBusy;
`ifdef UART_TX_FIFO_LEVEL_EN
    logic [4:0] level;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tx_count = 0;
    int last_tx_cyc = 0;
    int frame_len = 100;
    int busy_cnt;
    int silent_base = 0;
    logic force_busy = 1'b0;
    logic silent_mode = 1'b0;
    logic prev_txen = 1'b0;
    logic [7:0] exp_q [$];

    uart_tx_fifo #(.ADDR_BITS(4), .DATA_BITS(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .wrEnable      (wrEnable),
        .wrData        (wrData),
        .full          (full),
        .empty         (empty),
        .overflow      (overflow),
        .clearOverflow (clearOverflow),
        .txEnable      (txEnable),
        .txData        (txData),
        .txBusy        (txBusy)
`ifdef UART_TX_FIFO_LEVEL_EN
        ,
        .level         (level)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // UART model: busy for frame_len cycles starting the cycle after txEnable
    always @(posedge clk or posedge rst) begin
        if (rst) busy_cnt <= 0;
        else if (txEnable) busy_cnt <= frame_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign txBusy = force_busy || (busy_cnt != 0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (txEnable) begin
            check("txen_pulse_width", {31'd0, prev_txen}, 32'd0);
            check("issue_while_busy", {31'd0, txBusy}, 32'd0);
            check("tx_expected_pending", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() != 0) check("tx_data_order", {24'd0, txData}, {24'd0, exp_q.pop_front()});
            if (silent_mode && tx_count > silent_base) check("silent_gap", cyc - last_tx_cyc, 32'd4);
            last_tx_cyc = cyc;
            tx_count++;
        end
        prev_txen = txEnable;
    end

    task automatic push(input logic [7:0] b);
        wrEnable = 1'b1;
        wrData   = b;
        exp_q.push_back(b);
        @(negedge clk);
        wrEnable = 1'b0;
    endtask

    task automatic wait_tx(input int target, input int budget);
        int n = 0;
        while (tx_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_tx_target", (tx_count >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        wrEnable = 1'b0;
        wrData = 8'h00;
        clearOverflow = 1'b0;
        @(negedge clk);
        #2;
        check("rst_txen", {31'd0, txEnable}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_txdata", {24'd0, txData}, 32'd0);
`ifdef UART_TX_FIFO_LEVEL_EN
        check("rst_level", {27'd0, level}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // single byte: txEnable two clocks after the push edge
        push(8'h41);
        check("single_txen_early", {31'd0, txEnable}, 32'd0);
        check("single_not_empty", {31'd0, empty}, 32'd0);
        @(negedge clk);
        check("single_txen", {31'd0, txEnable}, 32'd1);
        check("single_txdata", {24'd0, txData}, 32'h41);
        check("single_empty_after_pop", {31'd0, empty}, 32'd1);
        repeat (110) @(negedge clk);
        check("single_one_issue", tx_count, 32'd1);
        check("txdata_held_idle", {24'd0, txData}, 32'h41);

        // burst while UART busy, then overflow
        frame_len = 6;
        force_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push(i[7:0]);
            if (i == 14) check("burst_not_full_15", {31'd0, full}, 32'd0);
        end
        check("burst_full_16", {31'd0, full}, 32'd1);
`ifdef UART_TX_FIFO_LEVEL_EN
        check("burst_level_16", {27'd0, level}, 32'd16);
`endif
        wrEnable = 1'b1; wrData = 8'hAA;
        @(negedge clk);
        wrEnable = 1'b0;
        check("overflow_set", {31'd0, overflow}, 32'd1);
        check("overflow_still_full", {31'd0, full}, 32'd1);
        wrEnable = 1'b1; wrData = 8'hAB; clearOverflow = 1'b1;
        @(negedge clk);
        wrEnable = 1'b0;
        check("overflow_set_beats_clear", {31'd0, overflow}, 32'd1);
        @(negedge clk);
        clearOverflow = 1'b0;
        check("overflow_cleared", {31'd0, overflow}, 32'd0);
        check("busy_blocks_issue", tx_count, 32'd1);
        force_busy = 1'b0;
        wait_tx(17, 300);
        repeat (12) @(negedge clk);
        check("burst_drained", exp_q.size(), 32'd0);
        check("burst_issue_count", tx_count, 32'd17);

        // simultaneous push and pop at count 5
        force_busy = 1'b1;
        for (int i = 0; i < 5; i++) push(8'h60 + i[7:0]);
`ifdef UART_TX_FIFO_LEVEL_EN
        check("sim_level_before", {27'd0, level}, 32'd5);
`endif
        force_busy = 1'b0;
        wrEnable = 1'b1; wrData = 8'h50;
        exp_q.push_back(8'h50);
        @(negedge clk);
        wrEnable = 1'b0;
        check("sim_txen", {31'd0, txEnable}, 32'd1);
        check("sim_not_empty", {31'd0, empty}, 32'd0);
`ifdef UART_TX_FIFO_LEVEL_EN
        check("sim_level_kept", {27'd0, level}, 32'd5);
`endif
        wait_tx(23, 200);
        repeat (12) @(negedge clk);
        check("sim_drained", exp_q.size(), 32'd0);

        // silent transmitter: issues 4 clocks apart
        frame_len = 0;
        force_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(8'h80 + i[7:0]);
        wrEnable = 1'b1; wrData = 8'hEE;
        @(negedge clk);
        wrEnable = 1'b0;
        check("silent_overflow", {31'd0, overflow}, 32'd1);
        silent_base = tx_count;
        silent_mode = 1'b1;
        force_busy = 1'b0;
        wait_tx(39, 200);
        repeat (6) @(negedge clk);
        silent_mode = 1'b0;
        check("silent_issue_count", tx_count, 32'd39);
        check("silent_drained", exp_q.size(), 32'd0);

        // asynchronous reset mid-frame
        frame_len = 50;
        force_busy = 1'b1;
        push(8'hD0); push(8'hD1); push(8'hD2);
        force_busy = 1'b0;
        wait_tx(40, 20);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_txen", {31'd0, txEnable}, 32'd0);
        check("midrst_empty", {31'd0, empty}, 32'd1);
        check("midrst_full", {31'd0, full}, 32'd0);
        check("midrst_overflow", {31'd0, overflow}, 32'd0);
        check("midrst_txdata", {24'd0, txData}, 32'd0);
`ifdef UART_TX_FIFO_LEVEL_EN
        check("midrst_level", {27'd0, level}, 32'd0);
`endif
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_no_issue", tx_count, 32'd40);
        check("post_rst_empty", {31'd0, empty}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
